// File: rtl/avfs_apb_initiator.sv
// Single-beat command to APB bridge for the AVFS register block, with optional
// write readback check and periodic polling of address 0 into a status mirror.
module avfs_apb_initiator #(
  parameter int POLL_PERIOD = 1024,
  parameter int VERIFY      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        poll_en,
  output logic [3:0]  status_freq,
  output logic        status_ovr,
  output logic        apb_sel,
  output logic        apb_we,
  output logic [7:0]  apb_addr,
  output logic [31:0] apb_wdata,
  input  logic [31:0] apb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_VERIFY, S_READ, S_POLL, S_RESP
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(POLL_PERIOD - 1);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic [3:0]  freq_q, freq_d;
  logic        ovr_q, ovr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        poll_take;

  assign poll_take = (state_q == S_IDLE) && pend_q;

  // A wrap in the same cycle the pending request is consumed re-arms it.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (!poll_en) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (poll_take) pend_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    freq_d      = freq_q;
    ovr_d       = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_POLL;
        end else if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (VERIFY == 1 && addr_q == 8'd0) begin
          state_d = S_VERIFY;
        end else begin
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_VERIFY: begin
        rsp_rdata_d = apb_rdata;
        rsp_error_d = (apb_rdata[4:0] != wdata_q[4:0]);
        ovr_d       = apb_rdata[0];
        freq_d      = apb_rdata[4:1];
        state_d     = S_RESP;
      end
      S_READ: begin
        rsp_rdata_d = apb_rdata;
        rsp_error_d = 1'b0;
        if (addr_q == 8'd0) begin
          ovr_d  = apb_rdata[0];
          freq_d = apb_rdata[4:1];
        end
        state_d = S_RESP;
      end
      S_POLL: begin
        ovr_d   = apb_rdata[0];
        freq_d  = apb_rdata[4:1];
        state_d = S_IDLE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      freq_q      <= 4'hF;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      freq_q      <= freq_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
    end
  end

  // Bus outputs decode registered state only, so reset drops apb_sel at once.
  always_comb begin
    apb_sel   = (state_q == S_WRITE) || (state_q == S_VERIFY) ||
                (state_q == S_READ)  || (state_q == S_POLL);
    apb_we    = (state_q == S_WRITE);
    apb_addr  = ((state_q == S_WRITE) || (state_q == S_READ)) ? addr_q : 8'd0;
    apb_wdata = (state_q == S_WRITE) ? wdata_q : 32'd0;
  end

  assign cmd_ready   = (state_q == S_IDLE) && !pend_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign status_freq = freq_q;
  assign status_ovr  = ovr_q;

endmodule

// File: tb/tb_avfs_apb_initiator.sv
// Scoreboard bench for avfs_apb_initiator: randomized commands against an AVFS
// responder, with expectations from a register-level reference model.
module tb_avfs_apb_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        poll_en = 1'b0;
  logic [3:0]  status_freq;
  logic        status_ovr;
  logic        apb_sel;
  logic        apb_we;
  logic [7:0]  apb_addr;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;

  avfs_apb_initiator #(.POLL_PERIOD(16), .VERIFY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .poll_en(poll_en), .status_freq(status_freq), .status_ovr(status_ovr),
    .apb_sel(apb_sel), .apb_we(apb_we), .apb_addr(apb_addr),
    .apb_wdata(apb_wdata), .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // AVFS responder: register 0 is read/write, address 4 is a fixed ID word.
  logic [31:0] resp_reg0 = 32'h0000_001E;
  logic        corrupt = 1'b0;
  always_comb begin
    apb_rdata = 32'd0;
    if (apb_sel && !apb_we) begin
      if (apb_addr == 8'd0)      apb_rdata = corrupt ? 32'h0000_001F : resp_reg0;
      else if (apb_addr == 8'd4) apb_rdata = 32'hDEAD_BEEF;
    end
  end
  always @(posedge clk)
    if (apb_sel && apb_we && apb_addr == 8'd0) resp_reg0 <= apb_wdata;

  // Reference model: what the register block holds and what the mirror should show.
  logic [31:0] mdl_reg0 = 32'h0000_001E;
  logic [3:0]  mdl_freq = 4'hF;
  logic        mdl_ovr  = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  freq;
    logic        ovr;
    int          due;
  } exp_t;
  exp_t sbq[$];
  int   sel_log[$];

  // Monitor: pops the scoreboard on every response and checks bus rules.
  logic prev_sel = 1'b0;
  logic prev_we  = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          chk("status_freq", {28'd0, status_freq}, {28'd0, e.freq});
          chk("status_ovr", {31'd0, status_ovr}, {31'd0, e.ovr});
        end
      end
      if (apb_sel && prev_sel)
        chk("b2b_only_write_verify", {29'd0, prev_we, apb_we, apb_addr == 8'd0}, 32'd5);
      if (!apb_sel)
        chk("idle_bus_zero", {31'd0, apb_we} | {24'd0, apb_addr} | apb_wdata, 32'd0);
      if (apb_sel) sel_log.push_back(cyc);
    end
    prev_sel = rst_n && apb_sel;
    prev_we  = rst_n && apb_we;
  end

  // Call right after a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output int acc);
    exp_t e;
    int   n;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    end else begin
      acc   = cyc + 1;
      e.err = 1'b0;
      e.due = acc + ((w && a == 8'd0) ? 2 : 1);
      if (w) begin
        if (a == 8'd0) begin
          mdl_reg0 = d;
          e.rdata  = corrupt ? 32'h0000_001F : d;
          e.err    = (e.rdata[4:0] != d[4:0]);
          mdl_ovr  = e.rdata[0];
          mdl_freq = e.rdata[4:1];
        end else begin
          e.rdata = 32'd0;
        end
      end else begin
        if (a == 8'd0) begin
          e.rdata  = corrupt ? 32'h0000_001F : mdl_reg0;
          mdl_ovr  = e.rdata[0];
          mdl_freq = e.rdata[4:1];
        end else if (a == 8'd4) begin
          e.rdata = 32'hDEAD_BEEF;
        end else begin
          e.rdata = 32'd0;
        end
      end
      e.freq = mdl_freq;
      e.ovr  = mdl_ovr;
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_scoreboard", sbq.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, p, n, gap;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_status_freq", {28'd0, status_freq}, 32'hF);
    chk("rst_status_ovr", {31'd0, status_ovr}, 32'd0);
    chk("rst_apb_sel", {31'd0, apb_sel}, 32'd0);

    // Write with verify: write cycle then readback cycle.
    issue(1'b1, 8'd0, 32'h15, acc);
    @(negedge clk);
    chk("wv_write_cycle", {29'd0, apb_sel, apb_we, apb_addr == 8'd0}, 32'd7);
    chk("wv_write_data", apb_wdata, 32'h15);
    @(negedge clk);
    chk("wv_readback_cycle", {29'd0, apb_sel, apb_we, apb_addr == 8'd0}, 32'd5);
    drain();

    // Readback disagrees with the written value.
    corrupt = 1'b1;
    issue(1'b1, 8'd0, 32'h15, acc);
    @(negedge clk);
    drain();
    corrupt = 1'b0;

    // Read the ID word; mirror must not move.
    issue(1'b0, 8'd4, 32'd0, acc);
    @(negedge clk);
    chk("rd4_bus", {29'd0, apb_sel, apb_we, apb_addr == 8'd4}, 32'd5);
    drain();
    issue(1'b0, 8'd0, 32'd0, acc);
    @(negedge clk);
    drain();

    // Polling only: one bus read every 16 cycles, no responses.
    sel_log.delete();
    poll_en = 1'b1;
    repeat (70) @(negedge clk);
    chk("poll_count_min", {31'd0, sel_log.size() >= 4}, 32'd1);
    for (int i = 1; i < sel_log.size(); i++)
      chk("poll_spacing", sel_log[i] - sel_log[i-1], 32'd16);
    p = sel_log[sel_log.size()-1];
    n = 0;
    while (cyc != p + 15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("poll_align", cyc, p + 15);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'd4;
    chk("ready_low_poll_pending", {31'd0, cmd_ready}, 32'd0);
    issue(1'b0, 8'd4, 32'd0, acc);
    chk("accept_after_poll", acc, p + 18);
    @(negedge clk);
    drain();

    // Randomized traffic with polling running underneath.
    for (int k = 0; k < 150; k++) begin
      w = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 8'd0;
        1:       a = 8'd4;
        2:       a = 8'($urandom);
        default: a = 8'd0;
      endcase
      d = $urandom;
      issue(w, a, d, acc);
      gap = $urandom_range(0, 3);
      @(negedge clk);
      repeat (gap) @(negedge clk);
    end
    drain();

    // Reset in the middle of a write.
    poll_en = 1'b0;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'd4; cmd_wdata = 32'h1234_5678;
    chk("pre_reset_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #2;
    chk("sel_in_write", {31'd0, apb_sel}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sel_async_drop", {31'd0, apb_sel}, 32'd0);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    @(negedge clk);
    chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rr_rsp", {30'd0, rsp_valid, rsp_error} | rsp_rdata, 32'd0);
    chk("rr_status", {27'd0, status_freq, status_ovr}, 32'h1E);
    chk("rr_apb", {31'd0, apb_sel | apb_we} | {24'd0, apb_addr} | apb_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_sbq_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avfs_apb_initiator.md
# avfs_apb_initiator

APB-side initiator that programs and monitors the AVFS controller's register block (address 0: control/status, address 4: ID/status word). It sits between the power-management firmware or sequencer and the AVFS controller's select/write-enable APB port. It converts single-beat commands into APB accesses, optionally reads back and checks control writes, and periodically polls address 0 to keep a local mirror of the frequency setting and override state.

## Interface
- POLL_PERIOD, 1024: cycles between automatic status polls; legal range 2..65535
- VERIFY, 1: when 1, every write to address 0 is followed by a readback check

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  8  APB address
- cmd_wdata  in  32  write data; bit0 = override enable, bits[4:1] = frequency
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  read or readback data; 0 for writes without verify
- rsp_error  out  1  readback mismatch; qualified by rsp_valid
- poll_en  in  1  enables periodic polling
- status_freq  out  4  mirrored freq_setting
- status_ovr  out  1  mirrored override_en
- apb_sel  out  1  APB select
- apb_we  out  1  APB write enable
- apb_addr  out  8  APB address
- apb_wdata  out  32  APB write data
- apb_rdata  in  32  APB read data; combinational from responder, valid in the same cycle as apb_sel && !apb_we

## Operation
- FSM states: IDLE, WRITE, VERIFY, READ, POLL, RESP.
- cmd_ready = (state == IDLE) && !poll_pending. On acceptance, latch write, addr, and wdata, then go to WRITE or READ.
- In IDLE with poll_pending set: go to POLL and clear poll_pending. A pending poll has priority over a new command.
- WRITE: apb_sel=1, apb_we=1, apb_addr and apb_wdata come from the latch. The responder captures the write at the end of this cycle.
  - Next state is VERIFY if VERIFY==1 && addr==0; otherwise RESP with rsp_rdata=0 and rsp_error=0.
- VERIFY: apb_sel=1, apb_we=0, apb_addr=0. Sample apb_rdata at the end of the cycle into rsp_rdata.
  - rsp_error = (apb_rdata[4:0] != latched wdata[4:0]).
  - Update status_ovr=rdata[0] and status_freq=rdata[4:1].
  - Next state: RESP.
- READ: apb_sel=1, apb_we=0, apb_addr=latched addr. Sample apb_rdata into rsp_rdata and set rsp_error=0. If addr==0, update the status mirror. Next state: RESP.
- POLL: same bus cycle as VERIFY at address 0. Update the status mirror only; rsp_* are untouched and no rsp_valid is issued. Next state: IDLE.
- RESP: rsp_valid=1 for exactly one cycle. Next state: IDLE.
- In IDLE, RESP, and during reset: apb_sel=0, apb_we=0, apb_addr=0, apb_wdata=0. APB outputs are decoded from registered state and latches only; there is no combinational path from cmd_* to apb_*.
- Poll timer: 16-bit counter.
  - While poll_en=0, the counter and poll_pending are held at 0.
  - While poll_en=1, the counter increments every cycle. At POLL_PERIOD-1 it wraps to 0 and sets poll_pending.
  - If poll_pending is already set at wrap, it stays set; requests do not accumulate.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, status_freq=4'hF, status_ovr=0, all apb_* outputs = 0, counter=0, poll_pending=0.
- Reset asserted mid-transaction aborts it immediately: apb_sel drops asynchronously and no rsp_valid is issued for the aborted command.

## Timing
- Command accepted at edge E0.
- Write without verify: bus write in cycle E0..E1; rsp_valid in cycle E1..E2 (2 cycles after acceptance).
- Write to address 0 with VERIFY=1: write cycle, then readback cycle; rsp_valid 3 cycles after acceptance.
- Read: bus read in cycle E0..E1; rsp_valid in cycle E1..E2. rsp_rdata and rsp_error are stable from the rsp_valid cycle until the next response.
- Next command: earliest acceptance is at the edge ending the RESP cycle, plus one cycle (cmd_ready high again in IDLE). This gives 3-cycle throughput for reads.
- Poll: occupies 1 bus cycle plus 1 IDLE cycle; the status mirror updates at the end of the poll cycle.
- Each bus access is exactly one cycle of apb_sel. Consecutive accesses are separated by at least one cycle, except WRITE→VERIFY, which is back-to-back.

## Test plan
- Reset: after rst_n deassert, check cmd_ready=1, rsp_valid=0, status_freq=F, status_ovr=0, apb_sel=0.
- Write with verify: VERIFY=1, write addr 0, data 0x15, against an AVFS responder model.
  - Expect one write cycle with apb_wdata=0x15, then one read cycle at addr 0.
  - Expect rsp_valid 3 cycles after acceptance with rsp_rdata=0x15, rsp_error=0.
  - Expect status_freq=A, status_ovr=1.
- Verify mismatch: model returns 0x1F on readback after a write of 0x15. Expect rsp_error=1 and status_freq=F.
- Read addr 4: expect rsp_rdata=0xDEADBEEF 2 cycles after acceptance; status mirror unchanged.
- Polling: POLL_PERIOD=16, poll_en=1, no commands.
  - Expect a read at addr 0 every 16 cycles with no rsp_valid.
  - Assert cmd_valid on the cycle poll_pending sets: expect cmd_ready=0 until the poll completes, then the command is accepted.
- Reset during the WRITE cycle: apb_sel falls with rst_n, no rsp_valid follows, and all outputs return to their reset values.
